// File: rtl/scoreboard_register_file.sv
// Parametrised two-read/one-write register file with synchronous clear, optional
// hardwired zero register, same-cycle write bypass and a pending-write scoreboard.
module scoreboard_register_file #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter bit ZERO_REG   = 1'b1,
  parameter bit BYPASS     = 1'b1
) (
  input  logic                  clk,
  input  logic                  resetN,
  input  logic [ADDR_WIDTH-1:0] readRegister1,
  input  logic [ADDR_WIDTH-1:0] readRegister2,
  output logic [DATA_WIDTH-1:0] readData1,
  output logic [DATA_WIDTH-1:0] readData2,
  output logic                  readPending1,
  output logic                  readPending2,
  input  logic [ADDR_WIDTH-1:0] writeRegister,
  input  logic [DATA_WIDTH-1:0] writeData,
  input  logic                  regWrite,
  input  logic                  issueValid,
  input  logic [ADDR_WIDTH-1:0] issueRegister,
  output logic                  issueConflict,
  output logic [ADDR_WIDTH:0]   pendingCount
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] r_regs [DEPTH];
  logic [DEPTH-1:0]      r_pending;

  logic                       w_write_en;
  logic                       w_issue_en;
  logic [DEPTH-1:0]           w_pending_next;
  logic [1:0][ADDR_WIDTH-1:0] w_raddr;
  logic [1:0][DATA_WIDTH-1:0] w_rdata;
  logic [1:0]                 w_rpend;
  logic [1:0]                 w_zero;
  logic [1:0]                 w_fwd;

  assign w_write_en = regWrite   && !(ZERO_REG && (writeRegister == '0));
  assign w_issue_en = issueValid && !(ZERO_REG && (issueRegister == '0));

  always_ff @(posedge clk) begin
    if (!resetN) begin
      // NOTE: the array is cleared by reset, so it maps to flops, not a RAM macro.
      for (int i = 0; i < DEPTH; i++) r_regs[i] <= '0;
    end else if (w_write_en) begin
      // NOTE: non-blocking so every read this cycle sees the pre-edge contents.
      r_regs[writeRegister] <= writeData;
    end
  end

  // Clear first, then set: a new producer issued alongside the old writeback wins.
  always_comb begin
    w_pending_next = r_pending;
    if (regWrite)   w_pending_next[writeRegister] = 1'b0;
    if (w_issue_en) w_pending_next[issueRegister] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!resetN) r_pending <= '0;
    else         r_pending <= w_pending_next;
  end

  assign w_raddr = {readRegister2, readRegister1};

  always_comb begin
    // NOTE: defaults first so no path through this block can infer a latch.
    w_zero  = '0;
    w_fwd   = '0;
    w_rdata = '0;
    w_rpend = '0;
    for (int p = 0; p < 2; p++) begin
      w_zero[p]  = ZERO_REG && (w_raddr[p] == '0);
      w_fwd[p]   = BYPASS && regWrite && (writeRegister == w_raddr[p]);
      w_rdata[p] = w_zero[p] ? '0 : (w_fwd[p] ? writeData : r_regs[w_raddr[p]]);
      w_rpend[p] = !w_zero[p] && !w_fwd[p] && r_pending[w_raddr[p]];
    end
  end

  assign readData1    = w_rdata[0];
  assign readData2    = w_rdata[1];
  assign readPending1 = w_rpend[0];
  assign readPending2 = w_rpend[1];

  assign issueConflict = issueValid && r_pending[issueRegister]
                         && !(regWrite && (writeRegister == issueRegister));

  // Popcount of the registered vector, so it can never drift from the bits themselves.
  always_comb begin
    pendingCount = '0;
    for (int i = 0; i < DEPTH; i++) pendingCount = pendingCount + {{ADDR_WIDTH{1'b0}}, r_pending[i]};
  end

endmodule

// File: tb/tb_scoreboard_register_file.sv
// Drives two register-file variants (zero+bypass, and neither) with directed and
// random traffic, comparing every cycle against a behavioural array model.
module tb_scoreboard_register_file;

  localparam int NU = 2;
  localparam bit ZR [NU] = '{1'b1, 1'b0};
  localparam bit BP [NU] = '{1'b1, 1'b0};

  logic        clk = 1'b0;
  logic        resetN;
  logic [4:0]  rr1, rr2, wr, ir;
  logic [31:0] wd;
  logic        rw, iv;

  logic [31:0] rd1 [NU];
  logic [31:0] rd2 [NU];
  logic        rp1 [NU];
  logic        rp2 [NU];
  logic        conf [NU];
  logic [5:0]  cnt [NU];

  int n_checks = 0;
  int n_pass   = 0;
  bit cmp_en   = 1'b0;

  logic [31:0] m_regs [NU][32];
  bit          m_pend [NU][32];

  always #5 clk = ~clk;

  scoreboard_register_file #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .ZERO_REG(1'b1), .BYPASS(1'b1)) dut0 (
    .clk(clk), .resetN(resetN),
    .readRegister1(rr1), .readRegister2(rr2),
    .readData1(rd1[0]), .readData2(rd2[0]),
    .readPending1(rp1[0]), .readPending2(rp2[0]),
    .writeRegister(wr), .writeData(wd), .regWrite(rw),
    .issueValid(iv), .issueRegister(ir),
    .issueConflict(conf[0]), .pendingCount(cnt[0])
  );

  scoreboard_register_file #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .ZERO_REG(1'b0), .BYPASS(1'b0)) dut1 (
    .clk(clk), .resetN(resetN),
    .readRegister1(rr1), .readRegister2(rr2),
    .readData1(rd1[1]), .readData2(rd2[1]),
    .readPending1(rp1[1]), .readPending2(rp2[1]),
    .writeRegister(wr), .writeData(wd), .regWrite(rw),
    .issueValid(iv), .issueRegister(ir),
    .issueConflict(conf[1]), .pendingCount(cnt[1])
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Reference model: what each register / pending flag must read as, from the rules.
  function automatic logic [31:0] exp_data(input int k, input logic [4:0] a);
    if (ZR[k] && a == 0)               return 32'h0;
    if (BP[k] && rw && wr == a)        return wd;
    return m_regs[k][a];
  endfunction

  function automatic logic exp_pend(input int k, input logic [4:0] a);
    if (ZR[k] && a == 0)               return 1'b0;
    if (BP[k] && rw && wr == a)        return 1'b0;
    return m_pend[k][a];
  endfunction

  function automatic int exp_count(input int k);
    int n = 0;
    for (int i = 0; i < 32; i++) if (m_pend[k][i]) n++;
    return n;
  endfunction

  always @(posedge clk) begin
    for (int k = 0; k < NU; k++) begin
      if (!resetN) begin
        for (int i = 0; i < 32; i++) begin
          m_regs[k][i] = 32'h0;
          m_pend[k][i] = 1'b0;
        end
      end else begin
        if (rw && !(ZR[k] && wr == 0)) m_regs[k][wr] = wd;
        if (rw) m_pend[k][wr] = 1'b0;
        if (iv && !(ZR[k] && ir == 0)) m_pend[k][ir] = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      for (int k = 0; k < NU; k++) begin
        check($sformatf("u%0d_rd1", k),  64'(rd1[k]),  64'(exp_data(k, rr1)));
        check($sformatf("u%0d_rd2", k),  64'(rd2[k]),  64'(exp_data(k, rr2)));
        check($sformatf("u%0d_rp1", k),  64'(rp1[k]),  64'(exp_pend(k, rr1)));
        check($sformatf("u%0d_rp2", k),  64'(rp2[k]),  64'(exp_pend(k, rr2)));
        check($sformatf("u%0d_conf", k), 64'(conf[k]),
              64'(iv && m_pend[k][ir] && !(rw && wr == ir)));
        check($sformatf("u%0d_cnt", k),  64'(cnt[k]),  64'(exp_count(k)));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rw = 1'b0;
    iv = 1'b0;
  endtask

  initial begin
    resetN = 1'b0;
    rr1 = 5'd0; rr2 = 5'd0; wr = 5'd0; ir = 5'd0; wd = 32'h0; rw = 1'b0; iv = 1'b0;
    tick();
    resetN = 1'b1;
    cmp_en = 1'b1;
    #2;
    check("reset_cnt", 64'(cnt[0]), 64'd0);

    // Reset clear discards the write presented during the reset edge.
    rw = 1'b1; wr = 5'd5; wd = 32'hDEADBEEF; iv = 1'b1; ir = 5'd7;
    tick();
    idle(); rr1 = 5'd5; rr2 = 5'd7;
    #2;
    check("pre_reset_r5", 64'(rd1[0]), 64'hDEADBEEF);
    check("pre_reset_p7", 64'(rp2[0]), 64'd1);
    tick();
    resetN = 1'b0; rw = 1'b1; wr = 5'd9; wd = 32'hCAFEF00D; iv = 1'b1; ir = 5'd11;
    tick();
    resetN = 1'b1; idle(); rr1 = 5'd5; rr2 = 5'd7;
    #2;
    check("reset_r5", 64'(rd1[0]), 64'd0);
    check("reset_p7", 64'(rp2[0]), 64'd0);
    check("reset_cnt2", 64'(cnt[0]), 64'd0);
    rr1 = 5'd9;
    #1;
    check("reset_r9", 64'(rd1[0]), 64'd0);
    tick();

    // Zero register: writes and issues to r0 are dropped only when ZERO_REG=1.
    rw = 1'b1; wr = 5'd0; wd = 32'h12345678; iv = 1'b1; ir = 5'd0; rr1 = 5'd0; rr2 = 5'd0;
    #2;
    check("zero_rd_same", 64'(rd1[0]), 64'd0);
    check("zero_rp_same", 64'(rp1[0]), 64'd0);
    tick();
    idle();
    #2;
    check("zero_rd_next", 64'(rd1[0]), 64'd0);
    check("zero_cnt", 64'(cnt[0]), 64'd0);
    check("nozero_rd", 64'(rd1[1]), 64'h12345678);
    check("nozero_cnt", 64'(cnt[1]), 64'd1);
    tick();

    // Bypass vs. no bypass.
    rw = 1'b1; wr = 5'd3; wd = 32'h11111111;
    tick();
    rr1 = 5'd3; rw = 1'b1; wr = 5'd3; wd = 32'hA5A5A5A5;
    #2;
    check("bypass_rd1", 64'(rd1[0]), 64'hA5A5A5A5);
    check("nobypass_old", 64'(rd1[1]), 64'h11111111);
    tick();
    idle();
    #2;
    check("nobypass_new", 64'(rd1[1]), 64'hA5A5A5A5);
    tick();

    // Scoreboard lifecycle on r4.
    iv = 1'b1; ir = 5'd4;
    tick();
    idle(); rr1 = 5'd4;
    #2;
    check("life_pend", 64'(rp1[0]), 64'd1);
    check("life_cnt1", 64'(cnt[0]), 64'd1);
    tick();
    rw = 1'b1; wr = 5'd4; wd = 32'h44;
    #2;
    check("life_fwd_pend", 64'(rp1[0]), 64'd0);
    check("life_nobyp_pend", 64'(rp1[1]), 64'd1);
    check("life_cnt_same", 64'(cnt[0]), 64'd1);
    tick();
    idle();
    #2;
    check("life_cnt0", 64'(cnt[0]), 64'd0);
    tick();

    // Simultaneous set/clear keeps the register pending without a conflict.
    iv = 1'b1; ir = 5'd6;
    tick();
    rw = 1'b1; wr = 5'd6; wd = 32'h66; iv = 1'b1; ir = 5'd6;
    #2;
    check("simul_conf", 64'(conf[0]), 64'd0);
    tick();
    idle(); rr1 = 5'd6;
    #2;
    check("simul_pend", 64'(rp1[0]), 64'd1);
    check("simul_cnt", 64'(cnt[0]), 64'd1);
    tick();
    iv = 1'b1; ir = 5'd8;
    tick();
    iv = 1'b1; ir = 5'd8;
    #2;
    check("conflict_r8", 64'(conf[0]), 64'd1);
    tick();
    idle();
    #2;
    check("conflict_cnt", 64'(cnt[0]), 64'd2);
    tick();

    // Full scoreboard: every register issued, then every register written back.
    resetN = 1'b0;
    tick();
    resetN = 1'b1;
    for (int i = 0; i < 32; i++) begin
      iv = 1'b1; ir = 5'(i);
      tick();
    end
    idle();
    #2;
    check("full_cnt_zero", 64'(cnt[0]), 64'd31);
    check("full_cnt_nozero", 64'(cnt[1]), 64'd32);
    tick();
    for (int i = 0; i < 32; i++) begin
      rw = 1'b1; wr = 5'(i); wd = $urandom;
      tick();
    end
    idle();
    #2;
    check("empty_cnt0", 64'(cnt[0]), 64'd0);
    check("empty_cnt1", 64'(cnt[1]), 64'd0);
    tick();

    // Random traffic, biased towards address collisions.
    for (int c = 0; c < 10000; c++) begin
      resetN = ($urandom_range(0, 199) != 0);
      rr1 = 5'($urandom_range(0, 31));
      rr2 = ($urandom_range(0, 3) == 0) ? rr1 : 5'($urandom_range(0, 31));
      wr  = ($urandom_range(0, 3) == 0) ? rr1 : 5'($urandom_range(0, 31));
      ir  = ($urandom_range(0, 3) == 0) ? wr  : 5'($urandom_range(0, 31));
      wd  = $urandom;
      rw  = ($urandom_range(0, 1) == 1);
      iv  = ($urandom_range(0, 2) == 0);
      tick();
    end
    resetN = 1'b1;
    idle();
    tick();
    cmp_en = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
